maxpool_seq_ctrl: RTL and testbench

Sequencer for the max-pooling register stage. It accepts a stream of signed 32-bit activations and partitions it into windows of `cfg_win_len` elements. It drives the external max register's clear and data inputs so that the register accumulates each window's maximum, then presents each pooled result on a valid/ready output. It sits between the convolution output stream and the pooled-feature writer, and owns the max register for the duration of a job.

---
 rtl/maxpool_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_maxpool_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_seq_ctrl
// Brief    : Sequencer for the max-pooling register stage. Splits a stream
//            of signed activations into windows, steers the external max
//            register so it tracks each window maximum, and presents every
//            pooled result on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8,
    parameter int WIN_W  = 16
) (
    input  logic              clk,
    input  logic              master_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_win_len,
    input  logic [WIN_W-1:0]  cfg_num_win,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mreg_rst,
    output logic [DATA_W-1:0] mreg_din,
    input  logic [DATA_W-1:0] mreg_q,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err_cfg
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    elem_cnt;
    logic [CNT_W-1:0]    elem_cnt_nxt;
    logic [WIN_W-1:0]    win_cnt;
    logic [WIN_W-1:0]    win_cnt_nxt;
    logic [CNT_W-1:0]    win_len;
    logic [WIN_W-1:0]    num_win;
    logic [DATA_W-1:0]   out_hold;
    logic [DATA_W-1:0]   out_hold_nxt;
    logic [DATA_W-1:0]   max_val;
    logic                latch_cfg;
    logic                done_nxt;
    logic                err_nxt;

    // Running maximum candidate; the first element of a window loads directly
    // so the register's clear value never beats negative data. Ties keep mreg_q.
    always_comb begin
        max_val = mreg_q;
        if (elem_cnt == '0) begin
            max_val = in_data;
        end else if ($signed(in_data) > $signed(mreg_q)) begin
            max_val = in_data;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt    = state;
        elem_cnt_nxt = elem_cnt;
        win_cnt_nxt  = win_cnt;
        out_hold_nxt = out_hold;
        latch_cfg    = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        mreg_rst     = 1'b0;
        mreg_din     = mreg_q;

        case (state)
            S_IDLE: begin
                mreg_rst = 1'b1;
                mreg_din = '0;
                if (start) begin
                    if ((cfg_win_len != '0) && (cfg_num_win != '0)) begin
                        latch_cfg    = 1'b1;
                        elem_cnt_nxt = '0;
                        win_cnt_nxt  = '0;
                        state_nxt    = S_ACCUM;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    elem_cnt_nxt = '0;
                    win_cnt_nxt  = '0;
                    state_nxt    = S_IDLE;
                end else if (in_valid) begin
                    mreg_din = max_val;
                    if (elem_cnt == (win_len - CNT_ONE)) begin
                        elem_cnt_nxt = '0;
                        out_hold_nxt = max_val;
                        state_nxt    = S_EMIT;
                    end else begin
                        elem_cnt_nxt = elem_cnt + CNT_ONE;
                    end
                end
            end

            S_EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    out_hold_nxt = '0;
                    elem_cnt_nxt = '0;
                    win_cnt_nxt  = '0;
                    state_nxt    = S_IDLE;
                end else if (out_ready) begin
                    out_hold_nxt = '0;
                    if (win_cnt == (num_win - WIN_ONE)) begin
                        win_cnt_nxt = '0;
                        done_nxt    = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        win_cnt_nxt = win_cnt + WIN_ONE;
                        state_nxt   = S_ACCUM;
                    end
                end
            end

            default: begin
                state_nxt    = S_IDLE;
                elem_cnt_nxt = '0;
                win_cnt_nxt  = '0;
                out_hold_nxt = '0;
            end
        endcase
    end

    // The pooled result is held in its own register so out_data has no
    // combinational path from mreg_q and reads 0 outside EMIT.
    assign out_data = out_hold;

    // State, counters, latched config and registered pulses
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            state    <= S_IDLE;
            elem_cnt <= '0;
            win_cnt  <= '0;
            win_len  <= '0;
            num_win  <= '0;
            out_hold <= '0;
            done     <= 1'b0;
            err_cfg  <= 1'b0;
        end else begin
            state    <= state_nxt;
            elem_cnt <= elem_cnt_nxt;
            win_cnt  <= win_cnt_nxt;
            out_hold <= out_hold_nxt;
            done     <= done_nxt;
            err_cfg  <= err_nxt;
            if (latch_cfg) begin
                win_len <= cfg_win_len;
                num_win <= cfg_num_win;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_seq_ctrl
// Brief    : Self-checking bench for maxpool_seq_ctrl with an external max
//            register model and a scoreboard of expected pooled results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_seq_ctrl;

    logic        clk = 1'b0;
    logic        master_rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_win_len;
    logic [15:0] cfg_num_win;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mreg_rst;
    logic [31:0] mreg_din;
    logic [31:0] mreg_q;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err_cfg;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          hs_count = 0;
    int          done_count = 0;
    int          last_hs_cyc = 0;
    int          done_cyc = 0;
    int          acc_neg = 0;
    bit          chk_lat = 1'b0;

    always #5 clk = ~clk;

    maxpool_seq_ctrl #(.DATA_W(32), .CNT_W(8), .WIN_W(16)) dut (
        .clk         (clk),
        .master_rst_n(master_rst_n),
        .start       (start),
        .abort       (abort),
        .cfg_win_len (cfg_win_len),
        .cfg_num_win (cfg_num_win),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mreg_rst    (mreg_rst),
        .mreg_din    (mreg_din),
        .mreg_q      (mreg_q),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg)
    );

    // External max register driven by the controller
    always @(posedge clk) begin
        if (mreg_rst) mreg_q <= '0;
        else          mreg_q <= mreg_din;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each result handshake
    always @(negedge clk) begin
        if (master_rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                else                   check_eq("pooled_out", out_data, exp_q.pop_front());
                hs_count++;
                last_hs_cyc = cyc;
                if (chk_lat) check_eq("passthru_lat", 32'(cyc - acc_neg), 32'd1);
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] len, input logic [15:0] num);
        start       = 1'b1;
        cfg_win_len = len;
        cfg_num_win = num;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        int i;
        in_valid = 1'b1;
        in_data  = d;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i == 200) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        acc_neg = cyc;
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        step();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int dc0;
        master_rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; cfg_win_len = '0; cfg_num_win = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_mreg_rst", 32'(mreg_rst), 32'd1);
        check_eq("rst_mreg_din", mreg_din, 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err_cfg", 32'(err_cfg), 32'd0);
        step();
        master_rst_n = 1'b1;
        step();

        // Case 1: basic job
        hs0 = hs_count;
        start_job(8'd4, 16'd2);
        check_eq("c1_busy", 32'(busy), 32'd1);
        check_eq("c1_mreg_rst", 32'(mreg_rst), 32'd0);
        exp_q.push_back(32'd9);
        exp_q.push_back(-32'sd1);
        send(32'd3); send(-32'sd7); send(32'd9); send(32'd2);
        send(-32'sd5); send(-32'sd1); send(-32'sd8); send(-32'sd3);
        wait_done("c1");
        check_eq("c1_handshakes", 32'(hs_count - hs0), 32'd2);
        check_eq("c1_done_lat", 32'(done_cyc - last_hs_cyc), 32'd1);

        // Case 2: all-negative window, then ties
        start_job(8'd3, 16'd2);
        exp_q.push_back(-32'sd10);
        exp_q.push_back(32'd5);
        send(-32'sd10); send(-32'sd20); send(-32'sd30);
        send(32'd5); send(32'd5); send(32'd5);
        wait_done("c2");

        // Case 3: backpressure with input pending
        start_job(8'd2, 16'd2);
        out_ready = 1'b0;
        exp_q.push_back(32'd8);
        send(32'd4); send(32'd8);
        in_valid = 1'b1;
        in_data  = 32'd100;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("c3_out_valid", 32'(out_valid), 32'd1);
            check_eq("c3_in_ready", 32'(in_ready), 32'd0);
            check_eq("c3_out_data", out_data, 32'd8);
        end
        step();
        out_ready = 1'b1;
        exp_q.push_back(32'd100);
        send(32'd100); send(-32'sd3);
        wait_done("c3");

        // Case 4: config errors
        start_job(8'd0, 16'd3);
        check_eq("c4a_err", 32'(err_cfg), 32'd1);
        check_eq("c4a_busy", 32'(busy), 32'd0);
        check_eq("c4a_in_ready", 32'(in_ready), 32'd0);
        step();
        check_eq("c4a_err_pulse", 32'(err_cfg), 32'd0);
        start_job(8'd3, 16'd0);
        check_eq("c4b_err", 32'(err_cfg), 32'd1);
        check_eq("c4b_busy", 32'(busy), 32'd0);
        check_eq("c4b_in_ready", 32'(in_ready), 32'd0);
        step();
        check_eq("c4b_err_pulse", 32'(err_cfg), 32'd0);

        // Case 5a: reset after two of four elements
        dc0 = done_count;
        start_job(8'd4, 16'd1);
        send(32'd1); send(32'd2);
        master_rst_n = 1'b0;
        #1;
        check_eq("c5a_mreg_rst", 32'(mreg_rst), 32'd1);
        check_eq("c5a_mreg_din", mreg_din, 32'd0);
        check_eq("c5a_busy", 32'(busy), 32'd0);
        check_eq("c5a_in_ready", 32'(in_ready), 32'd0);
        check_eq("c5a_out_valid", 32'(out_valid), 32'd0);
        step(); step();
        master_rst_n = 1'b1;
        step(); step(); step();
        check_eq("c5a_no_done", 32'(done_count), 32'(dc0));
        start_job(8'd4, 16'd1);
        exp_q.push_back(32'd4);
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        wait_done("c5a");

        // Case 5b: abort while result is pending
        dc0 = done_count;
        start_job(8'd2, 16'd2);
        out_ready = 1'b0;
        send(32'd9); send(32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("c5b_out_valid", 32'(out_valid), 32'd0);
        check_eq("c5b_busy", 32'(busy), 32'd0);
        check_eq("c5b_mreg_rst", 32'(mreg_rst), 32'd1);
        check_eq("c5b_out_data", out_data, 32'd0);
        out_ready = 1'b1;
        step(); step(); step();
        check_eq("c5b_no_done", 32'(done_count), 32'(dc0));
        start_job(8'd4, 16'd1);
        exp_q.push_back(32'd4);
        send(32'd1); send(32'd2); send(32'd3); send(32'd4);
        wait_done("c5b");

        // Case 6: pass-through with random input gaps
        start_job(8'd1, 16'd3);
        exp_q.push_back(32'd7);
        exp_q.push_back(-32'sd2);
        exp_q.push_back(32'd0);
        chk_lat = 1'b1;
        repeat ($urandom_range(0, 3)) step();
        send(32'd7);
        repeat ($urandom_range(0, 3)) step();
        send(-32'sd2);
        repeat ($urandom_range(0, 3)) step();
        send(32'd0);
        wait_done("c6");
        chk_lat = 1'b0;

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
